vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream raster timing stage for the 640x480@60 VGA output path.
- Divides the 100 MHz board clock into a pixel-rate tick and runs the horizontal and vertical raster counters.
- Produces sync pulses, an active-video flag, zero-based pixel coordinates and line/frame strobes.
- The colour/sync output stage consumes these signals directly, with no further decode.

Parameters:
- CLK_DIV, 4: clk cycles per pixel (must be >=1).
- H_TOTAL, 800: pixels per line, counts 0..H_TOTAL-1.
- H_SYNC, 96: hsync asserted for h_count < H_SYNC.
- H_ACT_START, 144: first active h_count.
- H_ACT_END, 784: first h_count after the active region.
- V_TOTAL, 525: lines per frame.
- V_SYNC, 2: vsync asserted for v_count < V_SYNC.
- V_ACT_START, 35: first active v_count.
- V_ACT_END, 515: first v_count after the active region.
- SYNC_POL, 1: asserted level of hsync/vsync.

Ports:
- clk  in  1  system clock (100 MHz); the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  run enable; low freezes all state.
- pix_tick  out  1  one-clk pulse, once per pixel period.
- h_count  out  16  horizontal raster position.
- v_count  out  16  vertical raster position.
- hsync  out  1  horizontal sync, level SYNC_POL when asserted.
- vsync  out  1  vertical sync, level SYNC_POL when asserted.
- active  out  1  high inside the visible window.
- x  out  10  h_count-H_ACT_START when active, else 0.
- y  out  10  v_count-V_ACT_START when active, else 0.
- line_start  out  1  one-clk pulse when h_count wraps to 0.
- frame_start  out  1  one-clk pulse when (h_count,v_count) wraps to (0,0).

Behaviour:
- Reset, asynchronous on rst_n low:
  - Clears div_cnt, h_count, v_count, x, y, pix_tick, active, line_start, frame_start to 0.
  - hsync=vsync=SYNC_POL, consistent with count (0,0).
  - All state is frozen at these values until rst_n rises; reset mid-frame aborts the frame immediately.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 on each clk while en=1.
  - pix_tick is registered, high for the single clk cycle following the edge where div_cnt was CLK_DIV-1, so the period is exactly CLK_DIV clks.
  - CLK_DIV=1: pix_tick is high every cycle while en=1.
- Counters advance only on a clk edge where pix_tick=1 and en=1:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - At (H_TOTAL-1, V_TOTAL-1) both counters wrap to 0.
  - Counters never hold values >= their TOTAL.
- Decode, all outputs registered:
  - hsync, vsync, active, x and y are computed from the next counter values.
  - They therefore change on the same clk edge as h_count/v_count and always match the current counts; there is no pipeline skew.
  - hsync = SYNC_POL when h_count < H_SYNC, else ~SYNC_POL. vsync follows the same rule using v_count.
  - active = (H_ACT_START <= h_count < H_ACT_END) && (V_ACT_START <= v_count < V_ACT_END).
  - x and y are truncated to 10 bits.
- Strobes:
  - line_start is high for exactly one clk: the first clk in which h_count is 0 after a wrap.
  - frame_start behaves the same way for the (0,0) wrap.
  - Neither strobe fires on release from reset.
- en=0:
  - div_cnt, counters and all level outputs hold.
  - pix_tick, line_start and frame_start are forced to 0.
  - Resuming continues from the held div_cnt with no lost or extra pixel.
- Simultaneous line and frame wrap: line_start and frame_start assert in the same clk.

Test Plan:
- Reset/en: hold rst_n=0 for 5 clks, release with en=1 -> all counts 0, hsync=vsync=1, active=0, no strobe; first pix_tick at clk 4 after release.
- Divider: run 40 clks -> exactly 10 pix_tick pulses, 4 clks apart; rerun with CLK_DIV=1 -> pix_tick constantly high.
- Hsync and line wrap:
  - Hsync high for exactly 96 pixels (384 clks) per line.
  - h_count goes 799->0 and v_count goes 0->1 on the same edge, with a single line_start pulse.
- Frame:
  - Run 420000 pixels -> one frame_start, coincident with a line_start.
  - vsync high for exactly 1600 pixels (lines 0-1).
  - Frame period is 1,680,000 clks.
- Active window:
  - active first rises at (144,35) with x=0, y=0.
  - Last active pixel is (783,514) with x=639, y=479.
  - Exactly 307200 active pixels per frame; x=y=0 outside the window.
- Freeze/abort:
  - Drop en at (500,200) for 37 clks -> outputs hold and no strobes; counting resumes without skew.
  - Assert rst_n=0 at (300,400) -> immediate return to reset values.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing for the VGA output path: pixel-rate divider, h/v counters,
// and registered sync/active/coordinate/strobe decode aligned to the counts.
module vga_timing_gen #(
    parameter int   CLK_DIV     = 4,
    parameter int   H_TOTAL     = 800,
    parameter int   H_SYNC      = 96,
    parameter int   H_ACT_START = 144,
    parameter int   H_ACT_END   = 784,
    parameter int   V_TOTAL     = 525,
    parameter int   V_SYNC      = 2,
    parameter int   V_ACT_START = 35,
    parameter int   V_ACT_END   = 515,
    parameter logic SYNC_POL    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        pix_tick,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [15:0]   H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0]   V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0]   HS_END   = 16'(H_SYNC);
    localparam logic [15:0]   VS_END   = 16'(V_SYNC);
    localparam logic [15:0]   HA_BEG   = 16'(H_ACT_START);
    localparam logic [15:0]   HA_END   = 16'(H_ACT_END);
    localparam logic [15:0]   VA_BEG   = 16'(V_ACT_START);
    localparam logic [15:0]   VA_END   = 16'(V_ACT_END);

    logic [DW-1:0] div_cnt;
    logic          div_last;
    logic          pix_q, ls_q, fs_q;
    logic          h_wrap, v_wrap, act_nxt;
    logic [15:0]   h_nxt, v_nxt;

    always_comb begin
        div_last = (div_cnt == DIV_LAST);
        h_wrap   = (h_count == H_LAST);
        v_wrap   = (v_count == V_LAST);
        h_nxt    = h_wrap ? 16'd0 : h_count + 16'd1;
        v_nxt    = h_wrap ? (v_wrap ? 16'd0 : v_count + 16'd1) : v_count;
        act_nxt  = (h_nxt >= HA_BEG) && (h_nxt < HA_END) &&
                   (v_nxt >= VA_BEG) && (v_nxt < VA_END);
    end

    // pix_q is held while en is low so a tick pending at the freeze is
    // consumed on resume; the outputs are gated so nothing pulses meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            pix_q   <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            h_count <= '0;
            v_count <= '0;
            hsync   <= SYNC_POL;
            vsync   <= SYNC_POL;
            active  <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else if (en) begin
            div_cnt <= div_last ? '0 : div_cnt + 1'b1;
            pix_q   <= div_last;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            if (pix_q) begin
                h_count <= h_nxt;
                v_count <= v_nxt;
                hsync   <= (h_nxt < HS_END) ? SYNC_POL : ~SYNC_POL;
                vsync   <= (v_nxt < VS_END) ? SYNC_POL : ~SYNC_POL;
                active  <= act_nxt;
                x       <= act_nxt ? 10'(h_nxt - HA_BEG) : 10'd0;
                y       <= act_nxt ? 10'(v_nxt - VA_BEG) : 10'd0;
                ls_q    <= h_wrap;
                fs_q    <= h_wrap && v_wrap;
            end
        end else begin
            ls_q <= 1'b0;
            fs_q <= 1'b0;
        end
    end

    assign pix_tick    = pix_q & en;
    assign line_start  = ls_q & en;
    assign frame_start = fs_q & en;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunken CLK_DIV=1,
// inverted-polarity instance, both compared against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic        pix;
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        act;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
    } obs_t;

    logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;

    logic        pix0, hs0, vs0, act0, ls0, fs0;
    logic [15:0] h0, v0;
    logic [9:0]  x0, y0;
    logic        pix1, hs1, vs1, act1, ls1, fs1;
    logic [15:0] h1, v1;
    logic [9:0]  x1, y1;

    vga_timing_gen dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pix0),
        .h_count(h0), .v_count(v0), .hsync(hs0), .vsync(vs0), .active(act0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_TOTAL(20), .H_SYNC(3), .H_ACT_START(5), .H_ACT_END(17),
        .V_TOTAL(12), .V_SYNC(2), .V_ACT_START(3), .V_ACT_END(10), .SYNC_POL(1'b0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .pix_tick(pix1),
        .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1), .active(act1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Raster model: e = number of enabled clock edges since reset release,
    // le = whether the most recent edge was enabled.
    function automatic obs_t model(int e, bit en_now, bit le, int d, int ht, int hsn,
                                   int has, int hae, int vt, int vsn, int vas, int vae,
                                   bit pol);
        obs_t o;
        int p, h, v;
        bit act, adv;
        p   = (e == 0) ? 0 : (e - 1) / d;
        h   = p % ht;
        v   = (p / ht) % vt;
        act = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
        adv = le && (e > d) && ((e - 1) % d == 0);
        o.pix = en_now && (e > 0) && (e % d == 0);
        o.h   = 16'(h);
        o.v   = 16'(v);
        o.hs  = (h < hsn) ? pol : ~pol;
        o.vs  = (v < vsn) ? pol : ~pol;
        o.act = act;
        o.x   = act ? 10'(h - has) : 10'd0;
        o.y   = act ? 10'(v - vas) : 10'd0;
        o.ls  = en_now && adv && (h == 0);
        o.fs  = o.ls && (v == 0);
        return o;
    endfunction

    int E;
    bit le;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E  <= 0;
            le <= 1'b0;
        end else begin
            if (en) E <= E + 1;
            le <= en;
        end
    end

    obs_t g0, g1, m0, m1;
    assign g0 = {pix0, h0, v0, hs0, vs0, act0, x0, y0, ls0, fs0};
    assign g1 = {pix1, h1, v1, hs1, vs1, act1, x1, y1, ls1, fs1};
    always_comb begin
        m0 = model(E, en, le, 4, 800, 96, 144, 784, 525, 2, 35, 515, 1'b1);
        m1 = model(E, en, le, 1, 20, 3, 5, 17, 12, 2, 3, 10, 1'b0);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 3;
            if (g0 !== m0) begin errors++; $display("FAIL reset_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL reset_d1 got %h exp %h", g1, m1); end
            if ({hs0, vs0, act0, pix0, ls0, fs0} !== 6'b110000) begin
                errors++; $display("FAIL reset_levels got %b exp 110000", {hs0, vs0, act0, pix0, ls0, fs0});
            end
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks += 3;
            if (g0 !== m0) begin errors++; $display("FAIL release_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL release_d1 got %h exp %h", g1, m1); end
            if (pix0 !== (i == 4)) begin
                errors++; $display("FAIL first_tick clk %0d got %b exp %b", i, pix0, (i == 4));
            end
        end
    endtask

    task automatic test_divider();
        int pulses = 0, high1 = 0, last = -1, bad_gap = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks += 2;
            if (g0 !== m0) begin errors++; $display("FAIL div_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL div_d1 got %h exp %h", g1, m1); end
            if (pix0) begin
                if (last >= 0 && i - last != 4) bad_gap++;
                last = i;
                pulses++;
            end
            if (pix1) high1++;
        end
        checks += 3;
        if (pulses !== 10) begin errors++; $display("FAIL div_pulses got %0d exp 10", pulses); end
        if (bad_gap !== 0) begin errors++; $display("FAIL div_spacing got %0d bad gaps exp 0", bad_gap); end
        if (high1 !== 40) begin errors++; $display("FAIL div1_high got %0d exp 40", high1); end
    endtask

    task automatic test_line_wrap();
        int hs_cnt = 0, ls_cnt = 0, n = 0;
        logic [15:0] ph = '0, pv = '0;
        while (v0 != 16'd2 && n < 8000) begin
            @(negedge clk);
            n++;
            checks += 2;
            if (g0 !== m0) begin errors++; $display("FAIL line_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL line_d1 got %h exp %h", g1, m1); end
            if (v0 == 16'd1 && hs0) hs_cnt++;
            if (ls0) begin
                ls_cnt++;
                checks++;
                if (ph !== 16'd799 || h0 !== 16'd0 || v0 !== pv + 16'd1) begin
                    errors++;
                    $display("FAIL line_wrap got %0d,%0d->%0d,%0d exp 799,%0d->0,%0d", ph, pv, h0, v0, pv, pv + 1);
                end
            end
            ph = h0;
            pv = v0;
        end
        checks += 3;
        if (n >= 8000) begin errors++; $display("FAIL line_timeout got %0d cycles exp <8000", n); end
        if (hs_cnt !== 384) begin errors++; $display("FAIL hsync_width got %0d exp 384", hs_cnt); end
        if (ls_cnt !== 2) begin errors++; $display("FAIL line_start_count got %0d exp 2", ls_cnt); end
    endtask

    task automatic test_frame();
        int n = 0, vs_cnt = 0, act_cnt = 0, fs_extra = 0;
        bit seen = 0;
        logic [15:0] fh = '1, fv = '1, lh = '1, lv = '1;
        logic [9:0]  fx = '1, fy = '1, lx = '1, ly = '1;
        while (!fs1 && n < 400) begin
            @(negedge clk);
            n++;
            checks += 2;
            if (g0 !== m0) begin errors++; $display("FAIL frame_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL frame_d1 got %h exp %h", g1, m1); end
        end
        checks++;
        if (!fs1) begin errors++; $display("FAIL frame_timeout got no frame_start exp one within 400"); end
        for (int i = 0; i < 240; i++) begin
            if (i > 0) begin
                @(negedge clk);
                checks += 2;
                if (g0 !== m0) begin errors++; $display("FAIL frame_d0 got %h exp %h", g0, m0); end
                if (g1 !== m1) begin errors++; $display("FAIL frame_d1 got %h exp %h", g1, m1); end
                if (fs1) fs_extra++;
            end else begin
                checks++;
                if (!ls1 || h1 !== 16'd0 || v1 !== 16'd0) begin
                    errors++; $display("FAIL frame_coincide got ls=%b h=%0d v=%0d exp 1,0,0", ls1, h1, v1);
                end
            end
            if (vs1 == 1'b0) vs_cnt++;
            if (act1) begin
                if (!seen) begin fh = h1; fv = v1; fx = x1; fy = y1; seen = 1; end
                lh = h1; lv = v1; lx = x1; ly = y1;
                act_cnt++;
            end
        end
        @(negedge clk);
        checks += 7;
        if (!fs1) begin errors++; $display("FAIL frame_period got fs=%b exp 1 after 240 clks", fs1); end
        if (fs_extra !== 0) begin errors++; $display("FAIL frame_extra got %0d exp 0", fs_extra); end
        if (vs_cnt !== 40) begin errors++; $display("FAIL vsync_width got %0d exp 40", vs_cnt); end
        if (act_cnt !== 84) begin errors++; $display("FAIL active_count got %0d exp 84", act_cnt); end
        if ({fh, fv} !== {16'd5, 16'd3} || {fx, fy} !== 20'd0) begin
            errors++; $display("FAIL first_active got %0d,%0d x%0d y%0d exp 5,3 x0 y0", fh, fv, fx, fy);
        end
        if ({lh, lv} !== {16'd16, 16'd9} || {lx, ly} !== {10'd11, 10'd6}) begin
            errors++; $display("FAIL last_active got %0d,%0d x%0d y%0d exp 16,9 x11 y6", lh, lv, lx, ly);
        end
        if (g1 !== m1) begin errors++; $display("FAIL frame_d1 got %h exp %h", g1, m1); end
    endtask

    task automatic test_freeze();
        logic [15:0] hh0, hh1;
        for (int k = 0; k < 15; k++) begin
            int run = $urandom_range(1, 60);
            int off = (k == 0) ? 37 : $urandom_range(1, 40);
            en = 1'b1;
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                checks += 2;
                if (g0 !== m0) begin errors++; $display("FAIL freeze_run_d0 got %h exp %h", g0, m0); end
                if (g1 !== m1) begin errors++; $display("FAIL freeze_run_d1 got %h exp %h", g1, m1); end
            end
            hh0 = h0;
            hh1 = h1;
            en  = 1'b0;
            for (int i = 0; i < off; i++) begin
                @(negedge clk);
                checks += 3;
                if (g0 !== m0) begin errors++; $display("FAIL freeze_d0 got %h exp %h", g0, m0); end
                if (g1 !== m1) begin errors++; $display("FAIL freeze_d1 got %h exp %h", g1, m1); end
                if (h0 !== hh0 || h1 !== hh1 || {pix1, ls0, ls1, fs1} !== 4'b0) begin
                    errors++;
                    $display("FAIL freeze_hold got h0=%0d h1=%0d strobes=%b exp h0=%0d h1=%0d 0000",
                             h0, h1, {pix1, ls0, ls1, fs1}, hh0, hh1);
                end
            end
        end
        en = 1'b1;
    endtask

    task automatic test_abort();
        for (int k = 0; k < 3; k++) begin
            int run = $urandom_range(50, 300);
            en = 1'b1;
            for (int i = 0; i < run; i++) begin
                @(negedge clk);
                checks += 2;
                if (g0 !== m0) begin errors++; $display("FAIL abort_run_d0 got %h exp %h", g0, m0); end
                if (g1 !== m1) begin errors++; $display("FAIL abort_run_d1 got %h exp %h", g1, m1); end
            end
            rst_n = 1'b0;
            #1;
            checks += 2;
            if ({h0, v0, h1, v1, x1, y1} !== 84'd0 || {hs0, vs0, hs1, vs1, act0, act1, pix0, pix1} !== 8'b11000000) begin
                errors++;
                $display("FAIL abort_clear got h1=%0d v1=%0d x1=%0d sync=%b exp all zero, sync 11000000",
                         h1, v1, x1, {hs0, vs0, hs1, vs1, act0, act1, pix0, pix1});
            end
            if (g1 !== m1) begin errors++; $display("FAIL abort_d1 got %h exp %h", g1, m1); end
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks += 2;
            if (g0 !== m0) begin errors++; $display("FAIL abort_resume_d0 got %h exp %h", g0, m0); end
            if (g1 !== m1) begin errors++; $display("FAIL abort_resume_d1 got %h exp %h", g1, m1); end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_line_wrap();
        test_frame();
        test_freeze();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
